// File: rtl/mypkg.sv
// Cache geometry, controller state/op encodings and the per-way line record
// shared by cache_ctrl and lru_update.
package mypkg;
    localparam int i_size     = 64;
    localparam int d_size     = 6;
    localparam int c_size     = 14;
    localparam int a_size     = 8;
    localparam int way_bits   = $clog2(a_size);
    localparam int index_bits = c_size - way_bits - d_size;
    localparam int tag_bits   = i_size - index_bits - d_size;
    localparam int num_sets   = 1 << index_bits;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_INVAL = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [tag_bits-1:0] tag;
        logic [way_bits-1:0] age;
    } line_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/lru_update.sv
// Age-based LRU for one set: ages after touching a way, plus the replacement
// victim (lowest invalid way, otherwise the oldest way).
module lru_update
    import mypkg::*;
(
    input  logic [a_size-1:0][way_bits-1:0] ages_i,
    input  logic [a_size-1:0]               valid_i,
    input  logic [way_bits-1:0]             touch_i,
    output logic [a_size-1:0][way_bits-1:0] ages_o,
    output logic [way_bits-1:0]             victim_o
);
    always_comb begin
        ages_o   = ages_i;
        victim_o = '0;
        for (int w = 0; w < a_size; w++) begin
            if (way_bits'(w) == touch_i)
                ages_o[w] = '0;
            else if (ages_i[w] < ages_i[touch_i])
                ages_o[w] = ages_i[w] + way_bits'(1);
            if (ages_i[w] == '1)
                victim_o = way_bits'(w);
        end
        // Downward scan so the lowest-numbered invalid way is the one kept.
        for (int w = a_size - 1; w >= 0; w--)
            if (!valid_i[w])
                victim_o = way_bits'(w);
    end
endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for the 8-way write-back cache: tag/state store,
// hit/miss resolution and the memory-side writeback/fill handshake.
module cache_ctrl
    import mypkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [i_size-1:0]   req_addr,
    output logic                resp_valid,
    output logic                resp_hit,
    output logic [way_bits-1:0] resp_way,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [i_size-1:0]   mem_req_addr,
    input  logic                mem_done,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);
    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [tag_bits-1:0]    tag_q, tag_d, wb_tag_q, wb_tag_d;
    logic [index_bits-1:0]  idx_q, idx_d;
    logic [way_bits-1:0]    way_q, way_d;
    logic                   hit_q, hit_d;
    logic                   resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
    logic [way_bits-1:0]    resp_way_q, resp_way_d;
    logic                   mem_req_valid_q, mem_req_valid_d, mem_req_we_q, mem_req_we_d;
    logic [i_size-1:0]      mem_req_addr_q, mem_req_addr_d;
    logic [31:0]            hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    line_t [a_size-1:0]     lines_q [num_sets];
    line_t [a_size-1:0]     set_cur, set_d;
    logic                   set_we;

    logic [a_size-1:0]                 hit_vec, valid_vec;
    logic [way_bits-1:0]               hit_way, touch_way, victim;
    logic [a_size-1:0][way_bits-1:0]   ages, ages_new;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[d_size-1:0];

    assign set_cur = lines_q[idx_q];

    always_comb begin
        hit_vec   = '0;
        valid_vec = '0;
        ages      = '0;
        hit_way   = '0;
        for (int w = 0; w < a_size; w++) begin
            valid_vec[w] = set_cur[w].valid;
            ages[w]      = set_cur[w].age;
            if (set_cur[w].valid && set_cur[w].tag == tag_q) begin
                hit_vec[w] = 1'b1;
                hit_way    = way_bits'(w);
            end
        end
    end

    // Hits touch in LOOKUP; fills touch the way chosen at LOOKUP.
    assign touch_way = (state_q == LOOKUP) ? hit_way : way_q;

    lru_update u_lru (
        .ages_i   (ages),
        .valid_i  (valid_vec),
        .touch_i  (touch_way),
        .ages_o   (ages_new),
        .victim_o (victim)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        wb_tag_d   = wb_tag_q;
        way_d      = way_q;
        hit_d      = hit_q;
        set_d      = set_cur;
        set_we     = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d    = op_e'(req_op);
                tag_d   = req_addr[i_size-1 -: tag_bits];
                idx_d   = req_addr[d_size +: index_bits];
                state_d = LOOKUP;
            end
            LOOKUP: begin
                if (op_q == OP_INVAL) begin
                    hit_d = |hit_vec;
                    way_d = hit_way;
                    if (!(|hit_vec)) begin
                        state_d = RESP;
                    end else if (set_cur[hit_way].dirty) begin
                        wb_tag_d = tag_q;
                        state_d  = WB_REQ;
                    end else begin
                        set_d[hit_way].valid = 1'b0;
                        set_d[hit_way].dirty = 1'b0;
                        set_we  = 1'b1;
                        state_d = RESP;
                    end
                end else if (|hit_vec) begin
                    hit_d  = 1'b1;
                    way_d  = hit_way;
                    set_we = 1'b1;
                    for (int w = 0; w < a_size; w++)
                        set_d[w].age = ages_new[w];
                    if (op_q == OP_WRITE)
                        set_d[hit_way].dirty = 1'b1;
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    state_d   = RESP;
                end else begin
                    hit_d      = 1'b0;
                    way_d      = victim;
                    wb_tag_d   = set_cur[victim].tag;
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    state_d    = (set_cur[victim].valid && set_cur[victim].dirty) ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ:   if (mem_req_ready) state_d = WB_WAIT;
            WB_WAIT: if (mem_done) begin
                if (op_q == OP_INVAL) begin
                    set_d[way_q].valid = 1'b0;
                    set_d[way_q].dirty = 1'b0;
                    set_we  = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: if (mem_req_ready) state_d = FILL_WAIT;
            FILL_WAIT: if (mem_done) begin
                set_d[way_q].tag   = tag_q;
                set_d[way_q].valid = 1'b1;
                set_d[way_q].dirty = (op_q == OP_WRITE);
                for (int w = 0; w < a_size; w++)
                    set_d[w].age = ages_new[w];
                set_we  = 1'b1;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        resp_valid_d    = (state_d == RESP);
        resp_hit_d      = resp_hit_q;
        resp_way_d      = resp_way_q;
        if (state_d == RESP) begin
            resp_hit_d = hit_d;
            resp_way_d = way_d;
        end
        mem_req_valid_d = (state_d == WB_REQ) || (state_d == FILL_REQ);
        mem_req_we_d    = (state_d == WB_REQ);
        mem_req_addr_d  = mem_req_addr_q;
        if (state_d == WB_REQ)
            mem_req_addr_d = {wb_tag_d, idx_d, {d_size{1'b0}}};
        else if (state_d == FILL_REQ)
            mem_req_addr_d = {tag_d, idx_d, {d_size{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            op_q            <= OP_READ;
            tag_q           <= '0;
            idx_q           <= '0;
            wb_tag_q        <= '0;
            way_q           <= '0;
            hit_q           <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_way_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
            for (int s = 0; s < num_sets; s++)
                for (int w = 0; w < a_size; w++)
                    lines_q[s][w] <= '{valid: 1'b0, dirty: 1'b0, tag: '0, age: way_bits'(w)};
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            tag_q           <= tag_d;
            idx_q           <= idx_d;
            wb_tag_q        <= wb_tag_d;
            way_q           <= way_d;
            hit_q           <= hit_d;
            resp_valid_q    <= resp_valid_d;
            resp_hit_q      <= resp_hit_d;
            resp_way_q      <= resp_way_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            if (set_we)
                lines_q[idx_q] <= set_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_hit      = resp_hit_q;
    assign resp_way      = resp_way_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_we    = mem_req_we_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus random traffic
// compared against a recency-list model of the cache.
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, resp_valid, resp_hit;
    logic [1:0]  req_op;
    logic [63:0] req_addr, mem_req_addr;
    logic [2:0]  resp_way;
    logic        mem_req_valid, mem_req_ready, mem_req_we, mem_done;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_way(resp_way), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_done(mem_done),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Model: per set, valid/dirty/tag per way and a recency list (MRU first).
    bit          m_valid [32][8];
    bit          m_dirty [32][8];
    logic [52:0] m_tag   [32][8];
    int          m_lst   [32][8];
    logic [31:0] m_hits, m_miss;

    bit          e_hit;  int e_way;  int e_nmem;
    bit          e_we   [2];
    logic [63:0] e_addr [2];

    bit          d_got, d_hit;  int d_way;  int d_nmem;  int d_lat;
    bit          d_we   [4];
    logic [63:0] d_addr [4];

    task automatic model_reset();
        for (int s = 0; s < 32; s++)
            for (int w = 0; w < 8; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; m_lst[s][w] = w;
            end
        m_hits = 0; m_miss = 0;
    endtask

    task automatic model_touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (m_lst[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_lst[s][i] = m_lst[s][i-1];
        m_lst[s][0] = w;
    endtask

    task automatic model_access(input logic [1:0] op, input logic [63:0] addr);
        int s, hw, v;
        logic [52:0] t;
        s = int'(addr[10:6]); t = addr[63:11]; hw = -1;
        e_nmem = 0; e_hit = 0; e_way = 0;
        for (int w = 7; w >= 0; w--) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        if (op == 2'd2) begin
            if (hw >= 0) begin
                e_hit = 1; e_way = hw;
                if (m_dirty[s][hw]) begin e_we[0] = 1; e_addr[0] = {t, addr[10:6], 6'd0}; e_nmem = 1; end
                m_valid[s][hw] = 0; m_dirty[s][hw] = 0;
            end
        end else if (hw >= 0) begin
            e_hit = 1; e_way = hw;
            model_touch(s, hw);
            if (op == 2'd1) m_dirty[s][hw] = 1;
            if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
        end else begin
            if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
            v = m_lst[s][7];
            for (int w = 7; w >= 0; w--) if (!m_valid[s][w]) v = w;
            e_way = v;
            if (m_valid[s][v] && m_dirty[s][v]) begin
                e_we[0] = 1; e_addr[0] = {m_tag[s][v], addr[10:6], 6'd0}; e_nmem = 1;
            end
            e_we[e_nmem] = 0; e_addr[e_nmem] = {t, addr[10:6], 6'd0}; e_nmem++;
            m_valid[s][v] = 1; m_dirty[s][v] = (op == 2'd1); m_tag[s][v] = t;
            model_touch(s, v);
        end
    endtask

    // Drives one request and plays the memory side; entered and left just after a negedge.
    task automatic run_req(input logic [1:0] op, input logic [63:0] addr,
                           input int rdy_dly, input int done_dly, input bit stray);
        int rw, dw, n;
        bit in_req, waiting;
        logic [63:0] h_addr;
        logic h_we;
        d_got = 0; d_nmem = 0; d_lat = 0; d_hit = 0; d_way = 0;
        in_req = 0; waiting = 0; rw = 0; dw = 0; h_addr = '0; h_we = 0;
        model_access(op, addr);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle: got %b want 1", req_ready); end
        req_valid = 1; req_op = op; req_addr = addr;
        @(negedge clk);
        req_valid = 0;
        for (n = 1; n < 400 && !d_got; n++) begin
            mem_done = 0;
            if (resp_valid === 1'b1) begin
                d_got = 1; d_lat = n; d_hit = resp_hit; d_way = int'(resp_way);
            end else if (mem_req_ready) begin
                if (d_nmem < 4) begin d_we[d_nmem] = h_we; d_addr[d_nmem] = h_addr; end
                d_nmem++;
                mem_req_ready = 0; in_req = 0; waiting = 1; dw = done_dly;
            end else if (mem_req_valid === 1'b1) begin
                if (!in_req) begin
                    in_req = 1; h_addr = mem_req_addr; h_we = mem_req_we; rw = rdy_dly;
                    if (stray) mem_done = 1;
                end else begin
                    checks++;
                    if (mem_req_addr !== h_addr || mem_req_we !== h_we) begin
                        errors++;
                        $display("FAIL mem_req_stable: got addr %h we %b want addr %h we %b", mem_req_addr, mem_req_we, h_addr, h_we);
                    end
                end
                if (rw == 0) mem_req_ready = 1; else rw--;
            end else if (waiting) begin
                if (dw == 0) begin mem_done = 1; waiting = 0; end else dw--;
            end
            if (!d_got) @(negedge clk);
        end
        checks++;
        if (!d_got) begin errors++; $display("FAIL resp_timeout: got no resp_valid want resp within 400 cycles"); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_after_resp: got %b want 1", req_ready); end
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = 0; req_op = 0; req_addr = '0; mem_req_ready = 0; mem_done = 0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_way, mem_req_valid, mem_req_we} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000000", {req_ready, resp_valid, resp_hit, resp_way, mem_req_valid, mem_req_we});
        end
        checks++;
        if (mem_req_addr !== 64'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_req_addr); end
        checks++;
        if (hit_count !== 0 || miss_count !== 0) begin
            errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_miss_then_hit();
        run_req(2'd0, 64'h1040, 0, 2, 0);
        checks++;
        if (d_hit !== 0 || d_way !== 0 || d_nmem !== 1) begin
            errors++; $display("FAIL first_read_miss: got hit %b way %0d nmem %0d want 0 0 1", d_hit, d_way, d_nmem);
        end
        checks++;
        if (d_we[0] !== 0 || d_addr[0] !== 64'h1040) begin
            errors++; $display("FAIL first_fill: got we %b addr %h want 0 1040", d_we[0], d_addr[0]);
        end
        run_req(2'd0, 64'h1040, 0, 0, 0);
        checks++;
        if (d_hit !== 1 || d_lat !== 2 || d_nmem !== 0) begin
            errors++; $display("FAIL read_hit: got hit %b lat %0d nmem %0d want 1 2 0", d_hit, d_lat, d_nmem);
        end
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            errors++; $display("FAIL counts_after_hit: got %0d/%0d want 1/1", hit_count, miss_count);
        end
    endtask

    task automatic test_eviction();
        for (int tg = 2; tg <= 11; tg++) begin
            run_req(2'd1, {53'(tg), 5'd1, 6'd0}, $urandom_range(0, 2), $urandom_range(0, 2), 0);
            checks++;
            if (d_hit !== e_hit || d_way !== e_way || d_nmem !== e_nmem) begin
                errors++;
                $display("FAIL evict_resp tag %0d: got hit %b way %0d nmem %0d want %b %0d %0d", tg, d_hit, d_way, d_nmem, e_hit, e_way, e_nmem);
            end
            if (tg == 10) begin
                checks++;
                if (d_nmem !== 2 || d_we[0] !== 1 || d_addr[0] !== 64'h1040 || d_way !== 0) begin
                    errors++; $display("FAIL evict_9th: got nmem %0d we %b addr %h way %0d want 2 1 1040 0", d_nmem, d_we[0], d_addr[0], d_way);
                end
            end
            if (tg == 11) begin
                checks++;
                if (d_nmem !== 2 || d_we[0] !== 1 || d_addr[0] !== 64'h1840 || d_way !== 1) begin
                    errors++; $display("FAIL evict_10th: got nmem %0d we %b addr %h way %0d want 2 1 1840 1", d_nmem, d_we[0], d_addr[0], d_way);
                end
            end
        end
    endtask

    task automatic test_invalidate();
        logic [31:0] h0, m0;
        run_req(2'd1, 64'h1040, 1, 1, 0);
        h0 = hit_count; m0 = miss_count;
        run_req(2'd2, 64'h1040, 2, 1, 0);
        checks++;
        if (d_hit !== 1 || d_way !== e_way || d_nmem !== 1 || d_we[0] !== 1 || d_addr[0] !== 64'h1040) begin
            errors++;
            $display("FAIL inval_dirty: got hit %b way %0d nmem %0d we %b addr %h want 1 %0d 1 1 1040", d_hit, d_way, d_nmem, d_we[0], d_addr[0], e_way);
        end
        run_req(2'd2, 64'h1040, 0, 0, 0);
        checks++;
        if (d_hit !== 0 || d_nmem !== 0 || d_lat !== 2) begin
            errors++; $display("FAIL inval_miss: got hit %b nmem %0d lat %0d want 0 0 2", d_hit, d_nmem, d_lat);
        end
        checks++;
        if (hit_count !== h0 || miss_count !== m0) begin
            errors++; $display("FAIL inval_counts: got %0d/%0d want %0d/%0d", hit_count, miss_count, h0, m0);
        end
    endtask

    task automatic test_stall();
        run_req(2'd1, {53'd12, 5'd1, 6'd0}, 0, 0, 0);
        run_req(2'd0, {53'd13, 5'd1, 6'd4}, 5, 3, 1);
        checks++;
        if (d_nmem !== e_nmem || d_nmem !== 2 || d_hit !== 0 || d_way !== e_way) begin
            errors++; $display("FAIL stall_miss: got nmem %0d hit %b way %0d want %0d 0 %0d", d_nmem, d_hit, d_way, e_nmem, e_way);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_we[i] !== e_we[i] || d_addr[i] !== e_addr[i]) begin
                    errors++; $display("FAIL stall_mem%0d: got we %b addr %h want %b %h", i, d_we[i], d_addr[i], e_we[i], e_addr[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_req(2'(i % 2 * 3), {53'(12 + i % 2), 5'd1, 6'(i)}, 0, 0, 0);
            checks++;
            if (d_hit !== 1 || d_lat !== 2 || d_way !== e_way) begin
                errors++; $display("FAIL b2b_hit%0d: got hit %b lat %0d way %0d want 1 2 %0d", i, d_hit, d_lat, d_way, e_way);
            end
        end
    endtask

    task automatic test_saturation();
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.miss_cnt_q;
        m_miss = 32'hFFFF_FFFE;
        @(negedge clk);
        run_req(2'd0, {53'd1, 5'd4, 6'd0}, 0, 0, 0);
        checks++;
        if (miss_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach: got %h want ffffffff", miss_count); end
        run_req(2'd0, {53'd2, 5'd4, 6'd0}, 0, 0, 0);
        checks++;
        if (miss_count !== 32'hFFFF_FFFF || miss_count !== m_miss) begin
            errors++; $display("FAIL sat_hold: got %h want ffffffff", miss_count);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        req_valid = 1; req_op = 2'd0; req_addr = {53'd5, 5'd2, 6'd0};
        @(negedge clk);
        req_valid = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (mem_req_valid === 1'b1) begin seen = 1; mem_req_ready = 1; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_fill_req: got no mem_req_valid want fill request"); end
        mem_req_ready = 0;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({req_ready, resp_valid, mem_req_valid, mem_req_we} !== 4'b1000 || mem_req_addr !== 64'd0 || hit_count !== 0 || miss_count !== 0) begin
            errors++;
            $display("FAIL async_reset: got ctl %b addr %h counts %0d/%0d want 1000 0 0/0", {req_ready, resp_valid, mem_req_valid, mem_req_we}, mem_req_addr, hit_count, miss_count);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        @(negedge clk);
        run_req(2'd0, {53'd5, 5'd2, 6'd0}, 0, 1, 0);
        checks++;
        if (d_hit !== 0 || d_nmem !== 1 || d_addr[0] !== {53'd5, 5'd2, 6'd0} || miss_count !== 32'd1) begin
            errors++; $display("FAIL post_reset_miss: got hit %b nmem %0d addr %h miss %0d want 0 1 %h 1", d_hit, d_nmem, d_addr[0], miss_count, {53'd5, 5'd2, 6'd0});
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [63:0] addr;
        for (int k = 0; k < 80; k++) begin
            op   = 2'($urandom_range(0, 3));
            addr = {53'($urandom_range(0, 11)), 5'($urandom_range(1, 3)), 6'($urandom_range(0, 63))};
            run_req(op, addr, $urandom_range(0, 3), $urandom_range(0, 3), 0);
            checks++;
            if (d_hit !== e_hit || ((op != 2'd2 || e_hit) && d_way !== e_way)) begin
                errors++; $display("FAIL rand%0d_resp: got hit %b way %0d want %b %0d", k, d_hit, d_way, e_hit, e_way);
            end
            checks++;
            if (d_nmem !== e_nmem) begin
                errors++; $display("FAIL rand%0d_nmem: got %0d want %0d", k, d_nmem, e_nmem);
            end else begin
                for (int i = 0; i < e_nmem; i++) begin
                    checks++;
                    if (d_we[i] !== e_we[i] || d_addr[i] !== e_addr[i]) begin
                        errors++; $display("FAIL rand%0d_mem%0d: got we %b addr %h want %b %h", k, i, d_we[i], d_addr[i], e_we[i], e_addr[i]);
                    end
                end
            end
            checks++;
            if (hit_count !== m_hits || miss_count !== m_miss) begin
                errors++; $display("FAIL rand%0d_counts: got %0d/%0d want %0d/%0d", k, hit_count, miss_count, m_hits, m_miss);
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_eviction();
        test_invalidate();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion want finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
